// File: rtl/mealy_mac_multi.sv
// Multi-channel Mealy multiply-accumulate engine with optional saturation and a
// single-entry registered output stage under valid/ready flow control.
module mealy_mac_multi #(
  parameter int unsigned DATA_W   = 9,
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned SAT      = 1,
  parameter int unsigned OUT_MODE = 0
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  input  logic        [CH_W-1:0]   in_ch,
  input  logic                     in_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic        [CH_W-1:0]   out_ch,
  output logic                     out_ovf
);

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0]    acc_q [CHANNELS];
  logic                       out_valid_q;
  logic signed [ACC_W-1:0]    out_acc_q;
  logic        [CH_W-1:0]     out_ch_q;
  logic                       out_ovf_q;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    base;
  logic        [ACC_W:0]      sum;
  logic                       ovf;
  logic signed [ACC_W-1:0]    acc_new;
  logic signed [ACC_W-1:0]    out_word;
  logic                       ch_legal;
  logic                       accept;

  // Full-width product so that (-2^(N-1))^2 stays exact.
  assign prod     = in_x * in_y;
  assign prod_ext = ACC_W'(prod);

  if (CHANNELS >= (1 << CH_W)) begin : g_all_legal
    assign ch_legal = 1'b1;
  end else begin : g_range_check
    assign ch_legal = (32'(in_ch) < CHANNELS);
  end

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    base    = in_clear ? '0 : acc_q[in_ch];
    sum     = {base[ACC_W-1], base} + {prod_ext[ACC_W-1], prod_ext};
    // Sign bits of the ACC_W+1 sum disagree exactly when the result leaves ACC_W range.
    ovf     = sum[ACC_W] ^ sum[ACC_W-1];
    acc_new = sum[ACC_W-1:0];
    if (SAT != 0 && ovf) begin
      acc_new = sum[ACC_W] ? AccMin : AccMax;
    end
    out_word = (OUT_MODE != 0) ? acc_new : base;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        acc_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ch_q    <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (accept && ch_legal) begin
        acc_q[in_ch] <= acc_new;
        out_valid_q  <= 1'b1;
        out_acc_q    <= out_word;
        out_ch_q     <= in_ch;
        out_ovf_q    <= ovf;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ch    = out_ch_q;
  assign out_ovf   = out_ovf_q;

endmodule
